control_sequencer: RTL

//  Registered, handshaked successor of the combinational control decoder: accepts one instruction
//  per valid/ready beat, decodes it into stack/register/ALU/jump controls, holds them through

---
 rtl/control_sequencer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: registered, handshaked instruction decoder.
// Accepts one instruction per valid/ready beat and decodes it into stack,
// register, ALU and jump controls one cycle later. A stack write holds its
// controls until the stack memory acknowledges it, or until a bounded wait
// expires and sets a sticky error.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_instr_valid/o_instr_ready   instruction handshake
//   i_instruction         instruction word, bit 0 is the MSB
//   i_stall               datapath stall, freezes state, counter and outputs
//   i_stk_ack             stack write complete
//   o_ctrl_valid          control word below is meaningful this cycle
//   o_stk_addr_sel, o_stk_wr, o_stk_sel, o_sp_ctrl  stack controls
//   o_reg_wr, o_reg_sel, o_carry_wr, o_alu_op       register/ALU controls
//   o_j_sel, o_j_tgt      jump condition and target
//   o_squashed            current control word is a squashed slot
//   o_err                 sticky stack-ack timeout
//
// Build option
//   CTRL_JUMP_SQUASH_EN   when defined, the instruction accepted after a jump
//                         word is turned into a valid, all-zero, squashed slot.
module control_sequencer #(
    parameter int unsigned INSTR_W     = 18,
    parameter int unsigned JTGT_W      = 6,
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned TMO_W       = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_instr_valid,
    output logic               o_instr_ready,
    input  logic [0:INSTR_W-1] i_instruction,
    input  logic               i_stall,
    input  logic               i_stk_ack,
    output logic               o_ctrl_valid,
    output logic               o_stk_addr_sel,
    output logic               o_stk_wr,
    output logic               o_stk_sel,
    output logic [1:0]         o_sp_ctrl,
    output logic               o_reg_wr,
    output logic               o_reg_sel,
    output logic               o_carry_wr,
    output logic [4:0]         o_alu_op,
    output logic [2:0]         o_j_sel,
    output logic [JTGT_W-1:0]  o_j_tgt,
    output logic               o_squashed,
    output logic               o_err
);

    // Registered control word: stk_addr_sel, stk_wr, stk_sel, sp_ctrl[2],
    // reg_wr, reg_sel, carry_wr, alu_op[5], j_sel[3], j_tgt[JTGT_W].
    localparam int unsigned CTRL_W = 16 + JTGT_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TMO_W-1:0]   cnt_q;
    logic [TMO_W-1:0]   cnt_next;
    logic [TMO_W-1:0]   cnt_inc;
    logic               err_next;
    logic [CTRL_W-1:0]  ctrl_q;
    logic [CTRL_W-1:0]  ctrl_next;
    logic [CTRL_W-1:0]  dec_word;
    logic               valid_next;
    logic               accept;
    logic               expire;
    logic               clear;

    logic               d_asel;
    logic               d_wr;
    logic               d_sel;
    logic               d_rwr;
    logic               d_rsel;
    logic               d_cwr;
    logic [4:0]         d_alu;
    logic [2:0]         d_jsel;
    logic [JTGT_W-1:0]  d_jtgt;

    // Bit 8 (and any bits past the jump target) carry no control meaning.
    logic               unused_instr;
    assign unused_instr = ^i_instruction;

    // Instruction decode; only class 00 produces non-zero controls.
    always_comb begin
        d_asel = 1'b0;
        d_wr   = 1'b0;
        d_sel  = 1'b0;
        d_rwr  = 1'b0;
        d_rsel = 1'b0;
        d_cwr  = 1'b0;
        d_alu  = '0;
        d_jsel = '0;
        d_jtgt = '0;
        if (i_instruction[0:1] == 2'b00) begin
            d_asel = ~i_instruction[3] & i_instruction[4];
            d_wr   = i_instruction[3] & i_instruction[7];
            d_sel  = i_instruction[3];
            d_rwr  = i_instruction[6];
            d_rsel = ~i_instruction[3] & ~i_instruction[4];
            d_cwr  = i_instruction[2];
            d_alu  = i_instruction[3:7];
            d_jsel = i_instruction[9:11];
            d_jtgt = i_instruction[12:11+JTGT_W];
        end
    end

    assign dec_word = {d_asel, d_wr, d_sel, d_asel, d_wr, d_rwr, d_rsel, d_cwr,
                       d_alu, d_jsel, d_jtgt};

    assign {o_stk_addr_sel, o_stk_wr, o_stk_sel, o_sp_ctrl, o_reg_wr, o_reg_sel,
            o_carry_wr, o_alu_op, o_j_sel, o_j_tgt} = ctrl_q;

    // Ready is a live handshake term: it drops in the same cycle as a stall.
    assign o_instr_ready = ~i_stall & ~o_err &
                           ((state == ST_IDLE) | ((state == ST_EXEC) & ~o_stk_wr));
    assign accept  = i_instr_valid & o_instr_ready;

    // cnt_q counts completed wait cycles; the wait expires at the end of
    // wait cycle ACK_TIMEOUT unless an ack arrives in that same cycle.
    assign cnt_inc = cnt_q + TMO_W'(1);
    assign expire  = (cnt_inc == TMO_W'(ACK_TIMEOUT));

    // Controls fall back to zero whenever the sequencer returns to IDLE.
    assign clear = ~i_stall &
                   (((state == ST_EXEC) & ~o_stk_wr & ~accept) |
                    ((state == ST_WAIT_ACK) & (i_stk_ack | expire)));

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            cnt_q <= '0;
            o_err <= 1'b0;
        end else begin
            state <= state_next;
            cnt_q <= cnt_next;
            o_err <= err_next;
        end
    end

    // Next-state, ack-timeout counter and sticky error
    always_comb begin
        state_next = state;
        cnt_next   = cnt_q;
        err_next   = o_err;
        if (!i_stall) begin
            case (state)
                ST_IDLE: begin
                    if (accept) state_next = ST_EXEC;
                end
                ST_EXEC: begin
                    if (o_stk_wr)     state_next = ST_WAIT_ACK;
                    else if (!accept) state_next = ST_IDLE;
                end
                ST_WAIT_ACK: begin
                    if (i_stk_ack) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else if (expire) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                        err_next   = 1'b1;
                    end else begin
                        cnt_next   = cnt_inc;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

`ifdef CTRL_JUMP_SQUASH_EN
    logic squash_pend_q;
    logic squash_pend_next;
    logic squashed_q;
    logic squashed_next;
    logic squash_now;

    // A jump word in EXEC squashes whatever is accepted next, either in the
    // same cycle or later via the pending flag.
    assign squash_now = squash_pend_q | ((state == ST_EXEC) & (o_j_sel != 3'b000));
    assign o_squashed = squashed_q;
`endif

    // Output next-value logic: load, clear or hold the control word
    always_comb begin
        ctrl_next  = ctrl_q;
        valid_next = o_ctrl_valid;
`ifdef CTRL_JUMP_SQUASH_EN
        squashed_next    = squashed_q;
        squash_pend_next = squash_pend_q;
        if (accept) begin
            squash_pend_next = 1'b0;
        end else if (~i_stall & (state == ST_EXEC) & (o_j_sel != 3'b000)) begin
            squash_pend_next = 1'b1;
        end
`endif
        if (accept) begin
            valid_next = 1'b1;
`ifdef CTRL_JUMP_SQUASH_EN
            ctrl_next     = squash_now ? '0 : dec_word;
            squashed_next = squash_now;
`else
            ctrl_next     = dec_word;
`endif
        end else if (clear) begin
            valid_next = 1'b0;
            ctrl_next  = '0;
`ifdef CTRL_JUMP_SQUASH_EN
            squashed_next = 1'b0;
`endif
        end
    end

    // Output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl_q       <= '0;
            o_ctrl_valid <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_next;
            o_ctrl_valid <= valid_next;
        end
    end

`ifdef CTRL_JUMP_SQUASH_EN
    // Squash bookkeeping registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            squash_pend_q <= 1'b0;
            squashed_q    <= 1'b0;
        end else begin
            squash_pend_q <= squash_pend_next;
            squashed_q    <= squashed_next;
        end
    end
`else
    assign o_squashed = 1'b0;
`endif

endmodule
